// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with one-cycle ops and a shift-add multiplier.
// Results and flags are registered; done pulses for one cycle on each update.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             zout,
  output logic             nout,
  output logic             vout,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t state_q, state_d;

  logic               accept;
  logic               mul_last;
  logic               is_mul;
  logic               is_ill;
  logic [WIDTH-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH:0]     step_sum;
  logic [WIDTH:0]     ea;
  logic [WIDTH:0]     eb;
  logic [WIDTH:0]     ci;
  logic [WIDTH:0]     arith;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic               alu_v;

  assign busy   = (state_q == MUL_RUN);
  assign is_mul = (op == 5'b10010);
  assign is_ill = op[4] & (op[3:0] > 4'd5);
  assign ea     = {1'b0, a};
  assign eb     = {1'b0, b};
  assign ci     = {{WIDTH{1'b0}}, cout};

  // One shift-add step: add multiplicand into the high half, shift right.
  assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_nx  = {step_sum, prod_q[WIDTH-1:1]};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept requests in IDLE, finish multiply after WIDTH steps.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mul_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (is_mul) state_d = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (cnt_q == WIDTH'(WIDTH - 1)) begin
          mul_last = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle op result, carry and overflow.
  always_comb begin
    arith = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (1'b1)
      (op == 5'b00000): alu_r = '0;
      (op == 5'b00001): begin
        alu_r = {a[WIDTH-2:0], 1'b0};
        alu_c = a[WIDTH-1];
      end
      (op == 5'b00010): alu_r = a;
      (op == 5'b00011): begin
        alu_r = {1'b0, a[WIDTH-1:1]};
        alu_c = a[0];
      end
      (op[4:2] == 3'b001): alu_r = ~(a | b);
      (op[4:2] == 3'b010),
      (op == 5'b10000): begin
        arith = ea + eb + (op[4] ? ci : '0);
        alu_r = arith[WIDTH-1:0];
        alu_c = arith[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1])
              & (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      (op[4:2] == 3'b011),
      (op == 5'b10001): begin
        arith = ea - eb - (op[4] ? ci : '0);
        alu_r = arith[WIDTH-1:0];
        alu_c = arith[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1])
              & (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      (op == 5'b10011): begin
        alu_r = {a[WIDTH-1], a[WIDTH-1:1]};
        alu_c = a[0];
      end
      (op == 5'b10100): begin
        alu_r = {a[WIDTH-2:0], a[WIDTH-1]};
        alu_c = a[WIDTH-1];
      end
      (op == 5'b10101): begin
        alu_r = {a[0], a[WIDTH-1:1]};
        alu_c = a[0];
      end
      default: ;
    endcase
  end

  // Result/flag registers and multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      zout      <= 1'b1;
      nout      <= 1'b0;
      vout      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (accept && is_mul) begin
        mcand_q <= a;
        prod_q  <= {{WIDTH{1'b0}}, b};
        cnt_q   <= '0;
      end else if (accept) begin
        done <= 1'b1;
        if (is_ill) begin
          illegal <= 1'b1;
        end else begin
          result    <= alu_r;
          result_hi <= '0;
          cout      <= alu_c;
          zout      <= (alu_r == '0);
          nout      <= alu_r[WIDTH-1];
          vout      <= alu_v;
        end
      end
      if (busy) begin
        prod_q <= prod_nx;
        cnt_q  <= cnt_q + WIDTH'(1);
        if (mul_last) begin
          result    <= prod_nx[WIDTH-1:0];
          result_hi <= prod_nx[2*WIDTH-1:WIDTH];
          cout      <= |prod_nx[2*WIDTH-1:WIDTH];
          zout      <= (prod_nx == '0);
          nout      <= prod_nx[2*WIDTH-1];
          vout      <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with a queue scoreboard for seq_alu.
// A monitor pops expected results on every done pulse.
module tb_seq_alu;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] h;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    logic       il;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       cout, zout, nout, vout;
  logic       busy, done, illegal;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .result(result), .result_hi(result_hi),
    .cout(cout), .zout(zout), .nout(nout), .vout(vout),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [7:0] r, input logic [7:0] h,
    input logic c, input logic z, input logic n,
    input logic v, input logic il);
    exp_t e;
    e.r = r; e.h = h; e.c = c; e.z = z;
    e.n = n; e.v = v; e.il = il;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t e;
    e.r = result; e.h = result_hi; e.c = cout;
    e.z = zout; e.n = nout; e.v = vout; e.il = illegal;
    return e;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare outputs on each done pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got %h want none",
                 actual());
      end else begin
        exp_t e;
        e = q.pop_front();
        if (actual() !== e) begin
          bad++;
          $display("FAIL result: got %h want %h", actual(), e);
        end
      end
    end
  end

  // Issue one op at a negedge; wait for done and check latency.
  task automatic run_op(input string name, input logic [4:0] o,
                        input logic [7:0] x, input logic [7:0] y,
                        input exp_t e, input int lat,
                        input bit poke);
    int n;
    int nb;
    bit got;
    q.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (poke && n >= 2 && n <= 4) begin
        start = 1'b1; op = 5'b01000; a = 8'h01; b = 8'h01;
      end else begin
        start = 1'b0;
        if (poke) begin a = 8'h00; b = 8'h00; end
      end
      if (busy === 1'b1) nb++;
      if (done === 1'b1) got = 1'b1;
    end
    chk({name, "_lat"}, n, got ? lat : 99);
    if (lat > 1) chk({name, "_busy"}, nb, lat - 1);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", actual(), mk(8'h00, 8'h00, 0, 1, 0, 0, 0));
    chk("rst_ctl", {busy, done}, 2'b00);
    rst_n = 1'b1;

    run_op("add_ff", 5'b01000, 8'hFF, 8'h01,
           mk(8'h00, 8'h00, 1, 1, 0, 0, 0), 1, 0);
    run_op("sub_80", 5'b01100, 8'h80, 8'h01,
           mk(8'h7F, 8'h00, 0, 0, 0, 1, 0), 1, 0);
    run_op("sbb_00", 5'b10001, 8'h00, 8'h00,
           mk(8'h00, 8'h00, 0, 1, 0, 0, 0), 1, 0);
    run_op("add_c1", 5'b01010, 8'hFF, 8'h01,
           mk(8'h00, 8'h00, 1, 1, 0, 0, 0), 1, 0);
    run_op("adc", 5'b10000, 8'h10, 8'h20,
           mk(8'h31, 8'h00, 0, 0, 0, 0, 0), 1, 0);
    run_op("add_c2", 5'b01001, 8'hFF, 8'h01,
           mk(8'h00, 8'h00, 1, 1, 0, 0, 0), 1, 0);
    run_op("sbb_c", 5'b10001, 8'h05, 8'h02,
           mk(8'h02, 8'h00, 0, 0, 0, 0, 0), 1, 0);
    run_op("mul_ff", 5'b10010, 8'hFF, 8'hFF,
           mk(8'h01, 8'hFE, 1, 0, 1, 0, 0), 9, 1);
    run_op("asr", 5'b10011, 8'h81, 8'h00,
           mk(8'hC0, 8'h00, 1, 0, 1, 0, 0), 1, 0);
    run_op("rol", 5'b10100, 8'h81, 8'h00,
           mk(8'h03, 8'h00, 1, 0, 0, 0, 0), 1, 0);
    run_op("ror", 5'b10101, 8'h01, 8'h00,
           mk(8'h80, 8'h00, 1, 0, 1, 0, 0), 1, 0);
    run_op("shl", 5'b00001, 8'h81, 8'h00,
           mk(8'h02, 8'h00, 1, 0, 0, 0, 0), 1, 0);
    run_op("shr", 5'b00011, 8'h81, 8'h00,
           mk(8'h40, 8'h00, 1, 0, 0, 0, 0), 1, 0);
    run_op("nor_0", 5'b00100, 8'h0F, 8'hF0,
           mk(8'h00, 8'h00, 0, 1, 0, 0, 0), 1, 0);
    run_op("nor_ff", 5'b00111, 8'h00, 8'h00,
           mk(8'hFF, 8'h00, 0, 0, 1, 0, 0), 1, 0);
    run_op("ld", 5'b00010, 8'h2A, 8'h55,
           mk(8'h2A, 8'h00, 0, 0, 0, 0, 0), 1, 0);
    @(negedge clk);
    run_op("add_2a", 5'b01011, 8'h20, 8'h0A,
           mk(8'h2A, 8'h00, 0, 0, 0, 0, 0), 1, 0);
    run_op("ill_1f", 5'b11111, 8'h00, 8'h00,
           mk(8'h2A, 8'h00, 0, 0, 0, 0, 1), 1, 0);
    run_op("ill_16", 5'b10110, 8'hFF, 8'hFF,
           mk(8'h2A, 8'h00, 0, 0, 0, 0, 1), 1, 0);
    repeat (3) @(negedge clk);
    chk("hold", actual(), mk(8'h2A, 8'h00, 0, 0, 0, 0, 0));
    run_op("rst_op", 5'b00000, 8'h12, 8'h34,
           mk(8'h00, 8'h00, 0, 1, 0, 0, 0), 1, 0);
    run_op("mul_15", 5'b10010, 8'h03, 8'h05,
           mk(8'h0F, 8'h00, 0, 0, 0, 0, 0), 9, 0);
    run_op("mul_0", 5'b10010, 8'h00, 8'h37,
           mk(8'h00, 8'h00, 0, 1, 0, 0, 0), 9, 0);
    run_op("sub_brw", 5'b01101, 8'h01, 8'h02,
           mk(8'hFF, 8'h00, 1, 0, 1, 0, 0), 1, 0);

    // Abort a multiply with reset in its fourth cycle.
    op = 5'b10010; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outs", actual(), mk(8'h00, 8'h00, 0, 1, 0, 0, 0));
    chk("abort_ctl", {busy, done}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    chk("abort_nodone", cnt, 0);
    run_op("add_ov", 5'b01000, 8'h7F, 8'h01,
           mk(8'h80, 8'h00, 0, 0, 1, 1, 0), 1, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width; legal values 4..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 op  input  5  opcode, sampled with start.
REQ-006 a, b  input  WIDTH each  operands, sampled with start.
REQ-007 result  output  WIDTH  registered result (low half for MUL).
REQ-008 result_hi  output  WIDTH  registered MUL high half; 0 after every other op.
REQ-009 cout, zout, nout, vout  output  1 each  registered carry, zero, negative, overflow flags.
REQ-010 busy  output  1  high while a multi-cycle op runs.
REQ-011 done  output  1  one-cycle pulse when result/flags update.
REQ-012 illegal  output  1  one-cycle pulse with done for an undefined opcode.

Function
REQ-013 op[4]=0 legacy map on op[3:0]: 0000 RST (result 0), 0001 SHL, 0010 LD (a), 0011 SHR, 01xx NOR ~(a|b), 10xx ADD a+b, 11xx SUB a-b.
REQ-014 op[4]=1: 10000 ADC a+b+cout, 10001 SBB a-b-cout, 10010 MUL unsigned, 10011 ASR, 10100 ROL, 10101 ROR; 10110..11111 illegal.
REQ-015 Arithmetic in WIDTH+1 bits; cout = bit WIDTH (carry for add, borrow=1 when minuend < subtrahend(+borrow-in)).
REQ-016 SHL/ROL: cout = a[WIDTH-1]; SHR/ASR/ROR: cout = a[0]; ROL/ROR rotate by 1 bit, no carry in ring.
REQ-017 RST, LD, NOR: cout = 0.
REQ-018 vout = signed two's-complement overflow for ADD/SUB/ADC/SBB; 0 for all other ops.
REQ-019 zout = 1 iff result==0 (MUL: iff full 2*WIDTH product==0); nout = result[WIDTH-1] (MUL: result_hi[WIDTH-1]).
REQ-020 MUL: cout = 1 iff result_hi != 0; result = product[WIDTH-1:0], result_hi = product[2*WIDTH-1:WIDTH].
REQ-021 FSM states IDLE, MUL_RUN; reset state IDLE.
REQ-022 IDLE, start=1, non-MUL op: result/flags registered on that edge; done=1 the following cycle (latency 1); stay IDLE.
REQ-023 IDLE, start=1, op=MUL: latch a,b, clear accumulator, go MUL_RUN, busy=1 next cycle.
REQ-024 MUL_RUN: one shift-add step per cycle using an internal WIDTH-bit step counter; after WIDTH steps write result/result_hi/flags, assert done, return IDLE; latency WIDTH+1 cycles from start.
REQ-025 start while busy=1 ignored completely (no queueing, operands not resampled).
REQ-026 Illegal opcode: result, result_hi and all flags hold previous values; done and illegal pulse for one cycle.
REQ-027 Outputs result, result_hi, flags hold between operations; change only on done cycles or reset.
REQ-028 Back-to-back: start asserted in the cycle done is high (busy=0) is accepted.

Reset
REQ-029 rst_n=0 forces immediately: state IDLE, result=0, result_hi=0, cout=0, zout=1, nout=0, vout=0, busy=0, done=0, illegal=0, step counter 0.
REQ-030 Reset during MUL_RUN aborts the multiply; no done pulse is produced for it.
REQ-031 First start honoured on the first rising edge with rst_n=1.

Verification (WIDTH=8)
REQ-032 ADD a=0xFF b=0x01 -> next cycle result=0x00, cout=1, zout=1, vout=0, done=1.
REQ-033 SUB a=0x80 b=0x01 -> result=0x7F, cout=0, vout=1, nout=0; then SBB a=0x00 b=0x00 with cout=0 -> result=0x00, zout=1.
REQ-034 MUL a=0xFF b=0xFF -> busy high 8 cycles, done on cycle 9 after start, result=0x01, result_hi=0xFE, cout=1; start pulses during busy ignored.
REQ-035 ASR a=0x81 -> result=0xC0, cout=1, nout=1; ROL a=0x81 -> result=0x03, cout=1.
REQ-036 op=11111 after ADD producing 0x2A -> done=1, illegal=1, result stays 0x2A, flags unchanged.
REQ-037 rst_n low mid-MUL (cycle 4) -> all outputs at reset values immediately, no done; new ADD after release completes normally.
